// File: rtl/intr_pkg.sv
// Shared constants and configuration check for the pending-interrupt arbiter.
package intr_pkg;

    localparam int unsigned RR_PTR_RST = 0;

    function automatic bit id_width_ok(input int unsigned intr_width,
                                       input int unsigned id_width);
        return (intr_width >= 1) && (intr_width <= 64) &&
               (id_width >= 1) && (id_width >= $clog2(intr_width));
    endfunction

endpackage

// File: rtl/intr_rr_arb.sv
// Combinational round-robin picker: first requesting index at or after ptr_i, wrapping.
module intr_rr_arb #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          gnt_valid_o,
    output logic [IW-1:0] gnt_id_o
);

    int unsigned ptr_ext;
    int unsigned idx;

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_id_o    = '0;
        ptr_ext     = 32'(ptr_i);
        idx         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (ptr_ext + k) % N;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_id_o    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/intr_pending_arb.sv
// Rising-edge interrupt latch with lost-event flags and round-robin delivery
// of one interrupt ID at a time over a valid/ready handshake.
module intr_pending_arb
    import intr_pkg::*;
#(
    parameter int unsigned INTR_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 3
) (
    input  logic                  slow_clk,
    input  logic                  slow_rst,
    input  logic [INTR_WIDTH-1:0] intr_in,
    input  logic [INTR_WIDTH-1:0] intr_en,
    input  logic [INTR_WIDTH-1:0] ovf_clr,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [ID_WIDTH-1:0]   evt_id,
    output logic [INTR_WIDTH-1:0] pending,
    output logic [INTR_WIDTH-1:0] overflow,
    output logic                  irq_out
);

    if (!id_width_ok(INTR_WIDTH, ID_WIDTH)) begin : g_cfg_err
        $error("intr_pending_arb: ID_WIDTH too small for INTR_WIDTH");
    end

    logic [INTR_WIDTH-1:0] intr_d_q;
    logic [INTR_WIDTH-1:0] pending_q, pending_d;
    logic [INTR_WIDTH-1:0] overflow_q, overflow_d;
    logic [INTR_WIDTH-1:0] rise_w, set_w, clr_w, ovf_hit_w, elig_w;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   evt_id_q, evt_id_d;
    logic [ID_WIDTH-1:0]   gnt_id;
    logic                  gnt_valid;
    logic                  evt_valid_q, evt_valid_d;
    logic                  slot_free, load;

    assign elig_w = pending_q & intr_en;

    intr_rr_arb #(
        .N  (INTR_WIDTH),
        .IW (ID_WIDTH)
    ) u_rr_arb (
        .req_i       (elig_w),
        .ptr_i       (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    always_comb begin
        rise_w      = intr_in & ~intr_d_q;
        set_w       = rise_w & intr_en;
        slot_free   = ~evt_valid_q | evt_ready;
        load        = slot_free & gnt_valid;
        clr_w       = '0;
        ovf_hit_w   = '0;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        rr_ptr_d    = rr_ptr_q;

        if (load) begin
            clr_w[gnt_id] = 1'b1;
        end
        pending_d = set_w | (pending_q & ~clr_w);

        // A new edge is lost if the line's previous event is still pending or parked in the slot.
        for (int unsigned i = 0; i < INTR_WIDTH; i++) begin
            ovf_hit_w[i] = set_w[i] &
                           (pending_q[i] |
                            (evt_valid_q && (evt_id_q == ID_WIDTH'(i)) &&
                             !(evt_ready && clr_w[i])));
        end
        overflow_d = ovf_hit_w | (overflow_q & ~ovf_clr);

        if (slot_free) begin
            evt_valid_d = gnt_valid;
            if (gnt_valid) begin
                evt_id_d = gnt_id;
                rr_ptr_d = (gnt_id == ID_WIDTH'(INTR_WIDTH - 1)) ? '0
                                                                 : gnt_id + ID_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge slow_clk) begin
        intr_d_q <= intr_in;
        if (slow_rst) begin
            pending_q   <= '0;
            overflow_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            rr_ptr_q    <= ID_WIDTH'(RR_PTR_RST);
        end else begin
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign irq_out   = evt_valid_q;

endmodule

// File: tb/tb_intr_pending_arb.sv
// Scoreboard bench: expected (id, cycle) deliveries are queued by the stimulus and
// checked by a monitor at each accepted handshake; status is checked directly.
module tb_intr_pending_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] intr_in, intr_en, ovf_clr;
    logic       evt_ready;
    logic       evt_valid, irq_out;
    logic [2:0] evt_id;
    logic [7:0] pending, overflow;

    typedef struct {
        int unsigned id;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned c;

    intr_pending_arb #(
        .INTR_WIDTH (8),
        .ID_WIDTH   (3)
    ) dut (
        .slow_clk  (clk),
        .slow_rst  (rst),
        .intr_in   (intr_in),
        .intr_en   (intr_en),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .pending   (pending),
        .overflow  (overflow),
        .irq_out   (irq_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_evt(input int unsigned id, input int unsigned at);
        exp_t e;
        e.id  = id;
        e.cyc = at;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got id %0d at cycle %0d, required no event", evt_id, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_id", 64'(evt_id), 64'(e.id));
                chk("sb_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        intr_in   = 8'h00;
        intr_en   = 8'hFF;
        ovf_clr   = 8'h00;
        evt_ready = 1'b1;
        step(2);
        chk("rst_valid", 64'(evt_valid), 64'h0);
        chk("rst_id", 64'(evt_id), 64'h0);
        chk("rst_pending", 64'(pending), 64'h0);
        chk("rst_overflow", 64'(overflow), 64'h0);
        chk("rst_irq", 64'(irq_out), 64'h0);
        rst = 1'b0;
        step(1);

        // single edge: event at t+2 only
        intr_in = 8'h04;
        c = cyc;
        exp_evt(2, c + 2);
        step(1);
        chk("t1_pend", 64'(pending), 64'h04);
        chk("t1_valid_early", 64'(evt_valid), 64'h0);
        step(1);
        chk("t1_valid", 64'(evt_valid), 64'h1);
        chk("t1_id", 64'(evt_id), 64'h2);
        chk("t1_pend_clr", 64'(pending), 64'h00);
        chk("t1_irq", 64'(irq_out), 64'h1);
        step(1);
        chk("t1_valid_gone", 64'(evt_valid), 64'h0);
        chk("t1_ovf", 64'(overflow), 64'h00);
        intr_in = 8'h00;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);

        // round robin from ptr 0, then ptr=6 makes line 7 beat line 2
        intr_in = 8'h29;
        c = cyc;
        exp_evt(0, c + 2);
        exp_evt(3, c + 3);
        exp_evt(5, c + 4);
        step(1);
        chk("t2_pend", 64'(pending), 64'h29);
        step(3);
        chk("t2_pend_done", 64'(pending), 64'h00);
        step(1);
        chk("t2_idle", 64'(evt_valid), 64'h0);
        intr_in = 8'hAD;
        c = cyc;
        exp_evt(7, c + 2);
        exp_evt(2, c + 3);
        step(4);
        chk("t2_idle2", 64'(evt_valid), 64'h0);
        intr_in = 8'h00;
        step(1);

        // backpressure
        evt_ready = 1'b0;
        intr_in = 8'h02;
        step(2);
        chk("t3_valid", 64'(evt_valid), 64'h1);
        chk("t3_id", 64'(evt_id), 64'h1);
        intr_in = 8'h12;
        step(1);
        chk("t3_pend", 64'(pending), 64'h10);
        chk("t3_id_hold", 64'(evt_id), 64'h1);
        step(2);
        chk("t3_id_hold2", 64'(evt_id), 64'h1);
        chk("t3_valid_hold", 64'(evt_valid), 64'h1);
        chk("t3_pend2", 64'(pending), 64'h10);
        evt_ready = 1'b1;
        c = cyc;
        exp_evt(1, c);
        exp_evt(4, c + 1);
        step(1);
        chk("t3_next_id", 64'(evt_id), 64'h4);
        step(1);
        chk("t3_valid_end", 64'(evt_valid), 64'h0);
        chk("t3_pend_end", 64'(pending), 64'h00);
        intr_in = 8'h00;
        step(1);

        // overflow set / clear / set-wins-over-clear
        evt_ready = 1'b0;
        intr_in = 8'h40;
        step(2);
        chk("t4_valid", 64'(evt_valid), 64'h1);
        chk("t4_id", 64'(evt_id), 64'h6);
        intr_in = 8'h00;
        step(1);
        intr_in = 8'h40;
        step(1);
        chk("t4_pend", 64'(pending), 64'h40);
        chk("t4_ovf", 64'(overflow), 64'h40);
        ovf_clr = 8'h40;
        step(1);
        chk("t4_ovf_clr", 64'(overflow), 64'h00);
        ovf_clr = 8'h00;
        intr_in = 8'h00;
        step(1);
        intr_in = 8'h40;
        ovf_clr = 8'h40;
        step(1);
        chk("t4_ovf_set_wins", 64'(overflow), 64'h40);
        chk("t4_pend2", 64'(pending), 64'h40);
        ovf_clr = 8'h00;
        evt_ready = 1'b1;
        c = cyc;
        exp_evt(6, c);
        exp_evt(6, c + 1);
        step(1);
        chk("t4_reload", 64'(evt_valid), 64'h1);
        chk("t4_pend_clr", 64'(pending), 64'h00);
        step(1);
        chk("t4_idle", 64'(evt_valid), 64'h0);
        ovf_clr = 8'h40;
        step(1);
        chk("t4_ovf_final", 64'(overflow), 64'h00);
        ovf_clr = 8'h00;
        intr_in = 8'h00;
        step(1);

        // masking
        intr_en = 8'hF7;
        intr_in = 8'h08;
        step(1);
        chk("t5_masked_pend", 64'(pending), 64'h00);
        step(1);
        chk("t5_masked_valid", 64'(evt_valid), 64'h0);
        chk("t5_masked_ovf", 64'(overflow), 64'h00);
        intr_in = 8'h00;
        intr_en = 8'hFF;
        step(1);
        intr_in = 8'h08;
        step(1);
        chk("t5_pend", 64'(pending), 64'h08);
        intr_en = 8'hF7;
        step(1);
        chk("t5_retained", 64'(pending), 64'h08);
        chk("t5_not_sent", 64'(evt_valid), 64'h0);
        step(2);
        chk("t5_retained2", 64'(pending), 64'h08);
        chk("t5_not_sent2", 64'(evt_valid), 64'h0);
        intr_en = 8'hFF;
        c = cyc;
        exp_evt(3, c + 1);
        step(1);
        chk("t5_sent", 64'(evt_valid), 64'h1);
        chk("t5_id", 64'(evt_id), 64'h3);
        step(1);
        chk("t5_pend_end", 64'(pending), 64'h00);
        intr_in = 8'h00;
        step(1);

        // reset with line high, then reset mid-handshake
        intr_in = 8'h01;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
        chk("t6_no_evt", 64'(evt_valid), 64'h0);
        chk("t6_no_pend", 64'(pending), 64'h00);
        evt_ready = 1'b0;
        intr_in = 8'h00;
        step(1);
        intr_in = 8'h01;
        step(2);
        chk("t6_valid", 64'(evt_valid), 64'h1);
        chk("t6_id", 64'(evt_id), 64'h0);
        rst = 1'b1;
        step(1);
        chk("t6_rst_valid", 64'(evt_valid), 64'h0);
        chk("t6_rst_pend", 64'(pending), 64'h00);
        chk("t6_rst_irq", 64'(irq_out), 64'h0);
        rst = 1'b0;
        evt_ready = 1'b1;
        step(3);
        chk("t6_no_restore", 64'(evt_valid), 64'h0);
        chk("t6_no_restore_pend", 64'(pending), 64'h00);

        chk("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
